// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle control FSM: state codes, opcodes,
// datapath select encodings and the packed control-output bundle.
package ctrl_pkg;

  localparam logic [3:0] S_RESET     = 4'd0;
  localparam logic [3:0] S_FETCH     = 4'd1;
  localparam logic [3:0] S_DECODE    = 4'd2;
  localparam logic [3:0] S_EXEC_ADD  = 4'd3;
  localparam logic [3:0] S_EXEC_ADDI = 4'd4;
  localparam logic [3:0] S_WB        = 4'd5;
  localparam logic [3:0] S_EXCP      = 4'd6;

  localparam logic [5:0] ADD       = 6'b000000;
  localparam logic [5:0] ADDI      = 6'b001000;
  localparam logic [5:0] RESET_OP  = 6'b111111;
  localparam logic [5:0] FUNCT_ADD = 6'b100000;

  localparam logic [2:0] ALU_PASS  = 3'b000;
  localparam logic [2:0] ALU_ADD   = 3'b001;
  localparam logic [2:0] ALU_SUB   = 3'b010;
  localparam logic [1:0] SRCA_PC   = 2'b00;
  localparam logic [1:0] SRCA_A    = 2'b01;
  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_4    = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] IORD_PC   = 2'b00;
  localparam logic [1:0] IORD_EXC  = 2'b10;
  localparam logic [2:0] PCSRC_ALU = 3'b000;
  localparam logic [2:0] PCSRC_MEM = 3'b011;

  typedef struct packed {
    logic       pc_write;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       ra_write;
    logic       rb_write;
    logic       reg_write;
    logic       alu_out_ctrl;
    logic       epc_ctrl;
    logic       reg_dst;
    logic       excp_ctrl;
    logic       rst_out;
    logic [2:0] alu_op;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] iord;
    logic [2:0] pc_src;
    logic [3:0] data_src;
  } ctrl_out_t;

endpackage

// File: rtl/ctrl_wait_cnt.sv
// Shared wait counter: clear/enable, terminal flag against a runtime limit.
// The next count is exported so the owner can register outputs from it.
module ctrl_wait_cnt #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic [CNT_W-1:0] cnt_d_o,
  output logic             term_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o   = cnt_q;
  assign cnt_d_o = cnt_d;
  assign term_o  = (cnt_q == limit_i);

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle CPU control unit with registered Moore outputs.
// Define CTRL_EXCP_EN to build the EXCP state (invalid opcode / overflow trap).
module multicycle_ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int MEM_WAIT   = 3,
  parameter int RST_CYCLES = 1,
  parameter int CNT_W      = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Of,
  input  logic [5:0] OPCode,
  input  logic [5:0] funct,
  output logic       PCWrite,
  output logic       MEMRead,
  output logic       MEMWrite,
  output logic       IRWrite,
  output logic       RAWrite,
  output logic       RBWrite,
  output logic       RegWrite,
  output logic       ALUOutCtrl,
  output logic       EPCControl,
  output logic       RegDst,
  output logic       ExcpContrl,
  output logic       rst_out,
  output logic [2:0] ALUOp,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] IorD,
  output logic [2:0] PCSrc,
  output logic [3:0] DataSrc,
  output logic [3:0] state_o
);

  localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] FETCH_LAST = CNT_W'(MEM_WAIT - 1);
`ifdef CTRL_EXCP_EN
  // One EPC cycle precedes the MEM_WAIT vector-read cycles.
  localparam logic [CNT_W-1:0] EXCP_LAST  = CNT_W'(MEM_WAIT);
`else
  logic unused_of;
  assign unused_of = Of;
`endif

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] limit, cnt_q, cnt_d;
  logic             term, cnt_clr, cnt_en;
  ctrl_out_t        out_q, out_d;

  always_comb begin
    limit = FETCH_LAST;
    if (state_q == S_RESET) limit = RST_LAST;
`ifdef CTRL_EXCP_EN
    if (state_q == S_EXCP)  limit = EXCP_LAST;
`endif
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET:  if (term) state_d = S_FETCH;
      S_FETCH:  if (term) state_d = S_DECODE;
      S_DECODE: begin
        if (OPCode == ADD && funct == FUNCT_ADD) state_d = S_EXEC_ADD;
        else if (OPCode == ADDI)                 state_d = S_EXEC_ADDI;
        else if (OPCode == RESET_OP)             state_d = S_RESET;
`ifdef CTRL_EXCP_EN
        else                                     state_d = S_EXCP;
`else
        else                                     state_d = S_FETCH;
`endif
      end
      S_EXEC_ADD, S_EXEC_ADDI: begin
        state_d = S_WB;
`ifdef CTRL_EXCP_EN
        if (Of) state_d = S_EXCP;
`endif
      end
      S_WB:     state_d = S_FETCH;
`ifdef CTRL_EXCP_EN
      S_EXCP:   if (term) state_d = S_FETCH;
`endif
      default:  state_d = S_RESET;
    endcase
  end

  assign cnt_clr = (state_d != state_q);
  assign cnt_en  = (state_q == S_RESET) || (state_q == S_FETCH) || (state_q == S_EXCP);

  ctrl_wait_cnt #(.CNT_W(CNT_W)) u_wait_cnt (
    .clk     (clk),
    .rst_n   (reset),
    .clr_i   (cnt_clr),
    .en_i    (cnt_en),
    .limit_i (limit),
    .cnt_o   (cnt_q),
    .cnt_d_o (cnt_d),
    .term_o  (term)
  );

  // Outputs are decoded from the next state/count so they are registered
  // yet line up with state_o in the same cycle.
  always_comb begin
    out_d = '0;
    case (state_d)
      S_RESET: out_d.rst_out = 1'b1;
      S_FETCH: begin
        out_d.mem_read  = 1'b1;
        out_d.iord      = IORD_PC;
        out_d.alu_src_a = SRCA_PC;
        out_d.alu_src_b = SRCB_4;
        out_d.alu_op    = ALU_ADD;
        if (cnt_d == FETCH_LAST) begin
          out_d.pc_write = 1'b1;
          out_d.ir_write = 1'b1;
          out_d.pc_src   = PCSRC_ALU;
        end
      end
      S_DECODE: begin
        out_d.ra_write = 1'b1;
        out_d.rb_write = 1'b1;
      end
      S_EXEC_ADD, S_EXEC_ADDI: begin
        out_d.alu_src_a    = SRCA_A;
        out_d.alu_src_b    = (state_d == S_EXEC_ADDI) ? SRCB_IMM : SRCB_B;
        out_d.alu_op       = ALU_ADD;
        out_d.alu_out_ctrl = 1'b1;
      end
      S_WB: begin
        out_d.reg_write = 1'b1;
        out_d.data_src  = 4'b0000;
        out_d.reg_dst   = (state_q == S_EXEC_ADD);
      end
`ifdef CTRL_EXCP_EN
      S_EXCP: begin
        // Cause is fixed on entry: 1 from an EXEC overflow, 0 from DECODE.
        out_d.excp_ctrl = (state_q == S_EXCP) ? out_q.excp_ctrl : (state_q != S_DECODE);
        if (cnt_d == '0) begin
          out_d.epc_ctrl  = 1'b1;
          out_d.alu_src_a = SRCA_PC;
          out_d.alu_src_b = SRCB_4;
          out_d.alu_op    = ALU_SUB;
        end else begin
          out_d.mem_read = 1'b1;
          out_d.iord     = IORD_EXC;
          if (cnt_d == EXCP_LAST) begin
            out_d.pc_write = 1'b1;
            out_d.pc_src   = PCSRC_MEM;
          end
        end
      end
`endif
      default: out_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_RESET;
      out_q         <= '0;
      out_q.rst_out <= 1'b1;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  end

  assign PCWrite    = out_q.pc_write;
  assign MEMRead    = out_q.mem_read;
  assign MEMWrite   = out_q.mem_write;
  assign IRWrite    = out_q.ir_write;
  assign RAWrite    = out_q.ra_write;
  assign RBWrite    = out_q.rb_write;
  assign RegWrite   = out_q.reg_write;
  assign ALUOutCtrl = out_q.alu_out_ctrl;
  assign EPCControl = out_q.epc_ctrl;
  assign RegDst     = out_q.reg_dst;
  assign ExcpContrl = out_q.excp_ctrl;
  assign rst_out    = out_q.rst_out;
  assign ALUOp      = out_q.alu_op;
  assign ALUSrcA    = out_q.alu_src_a;
  assign ALUSrcB    = out_q.alu_src_b;
  assign IorD       = out_q.iord;
  assign PCSrc      = out_q.pc_src;
  assign DataSrc    = out_q.data_src;
  assign state_o    = state_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: per-cycle expected control vectors are queued
// per instruction and compared one per clock against the DUT outputs.
module tb_multicycle_ctrl_fsm;

  localparam int MW = 3;
  localparam int RC = 2;
`ifdef CTRL_EXCP_EN
  localparam bit EXCP_EN = 1'b1;
`else
  localparam bit EXCP_EN = 1'b0;
`endif

  localparam logic [3:0] T_RESET = 4'd0, T_FETCH = 4'd1, T_DECODE = 4'd2,
                         T_EXA = 4'd3, T_EXI = 4'd4, T_WB = 4'd5, T_EXCP = 4'd6;

  localparam logic [11:0] B_PCW = 12'h800, B_MRD = 12'h400, B_IRW = 12'h100,
                          B_RAW = 12'h080, B_RBW = 12'h040, B_RGW = 12'h020,
                          B_AOC = 12'h010, B_EPC = 12'h008, B_RDST = 12'h004,
                          B_EXC = 12'h002, B_RST = 12'h001;

  logic       clk, reset, Of;
  logic [5:0] OPCode, funct;
  logic       PCWrite, MEMRead, MEMWrite, IRWrite, RAWrite, RBWrite, RegWrite;
  logic       ALUOutCtrl, EPCControl, RegDst, ExcpContrl, rst_out;
  logic [2:0] ALUOp, PCSrc;
  logic [1:0] ALUSrcA, ALUSrcB, IorD;
  logic [3:0] DataSrc, state_o;

  logic [31:0] exp_q[$];
  logic [31:0] dut_vec;
  int          n_vec, n_err;
  logic [5:0]  cur_op, cur_fn;
  logic        cur_of;

  multicycle_ctrl_fsm #(.MEM_WAIT(MW), .RST_CYCLES(RC), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .Of(Of), .OPCode(OPCode), .funct(funct),
    .PCWrite(PCWrite), .MEMRead(MEMRead), .MEMWrite(MEMWrite), .IRWrite(IRWrite),
    .RAWrite(RAWrite), .RBWrite(RBWrite), .RegWrite(RegWrite), .ALUOutCtrl(ALUOutCtrl),
    .EPCControl(EPCControl), .RegDst(RegDst), .ExcpContrl(ExcpContrl), .rst_out(rst_out),
    .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .IorD(IorD), .PCSrc(PCSrc),
    .DataSrc(DataSrc), .state_o(state_o)
  );

  assign dut_vec = {state_o, PCWrite, MEMRead, MEMWrite, IRWrite, RAWrite, RBWrite,
                    RegWrite, ALUOutCtrl, EPCControl, RegDst, ExcpContrl, rst_out,
                    ALUOp, ALUSrcA, ALUSrcB, IorD, PCSrc, DataSrc};

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk(logic [3:0] st, logic [11:0] strb, logic [2:0] aluop,
                                     logic [1:0] sa, logic [1:0] sb, logic [1:0] iord,
                                     logic [2:0] pcsrc);
    return {st, strb, aluop, sa, sb, iord, pcsrc, 4'b0000};
  endfunction

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected-trace builders
  task automatic push_reset(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(mk(T_RESET, B_RST, 3'b000, 2'b00, 2'b00, 2'b00, 3'b000));
  endtask

  task automatic push_fetch();
    for (int i = 0; i < MW; i++)
      exp_q.push_back(mk(T_FETCH, B_MRD | ((i == MW-1) ? (B_PCW | B_IRW) : 12'h000),
                         3'b001, 2'b00, 2'b01, 2'b00, 3'b000));
  endtask

  task automatic push_decode();
    exp_q.push_back(mk(T_DECODE, B_RAW | B_RBW, 3'b000, 2'b00, 2'b00, 2'b00, 3'b000));
  endtask

  task automatic push_exec(input bit is_add);
    exp_q.push_back(mk(is_add ? T_EXA : T_EXI, B_AOC, 3'b001, 2'b01,
                       is_add ? 2'b00 : 2'b10, 2'b00, 3'b000));
  endtask

  task automatic push_wb(input bit is_add);
    exp_q.push_back(mk(T_WB, B_RGW | (is_add ? B_RDST : 12'h000), 3'b000, 2'b00, 2'b00, 2'b00, 3'b000));
  endtask

  task automatic push_excp(input bit cause);
    logic [11:0] c;
    c = cause ? B_EXC : 12'h000;
    exp_q.push_back(mk(T_EXCP, B_EPC | c, 3'b010, 2'b00, 2'b01, 2'b00, 3'b000));
    for (int i = 1; i <= MW; i++)
      exp_q.push_back(mk(T_EXCP, B_MRD | c | ((i == MW) ? B_PCW : 12'h000), 3'b000,
                         2'b00, 2'b00, 2'b10, (i == MW) ? 3'b011 : 3'b000));
  endtask

  // Driver: one comparison per clock; OPCode/funct/Of carry real values only
  // in the cycle the DUT is meant to sample them, random noise otherwise.
  task automatic drain();
    logic [31:0] e;
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      check_vec("cycle", dut_vec, e);
      if (e[31:28] == T_DECODE) begin
        OPCode = cur_op; funct = cur_fn;
      end else begin
        OPCode = 6'($urandom_range(0, 63)); funct = 6'($urandom_range(0, 63));
      end
      Of = (e[31:28] == T_EXA || e[31:28] == T_EXI) ? cur_of : 1'($urandom_range(0, 1));
    end
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic of);
    bit is_add, is_addi;
    cur_op = op; cur_fn = fn; cur_of = of;
    is_add  = (op == 6'b000000 && fn == 6'b100000);
    is_addi = (op == 6'b001000);
    push_fetch();
    push_decode();
    if (is_add || is_addi) begin
      push_exec(is_add);
      if (of && EXCP_EN) push_excp(1'b1);
      else               push_wb(is_add);
    end else if (op == 6'b111111) begin
      push_reset(RC);
    end else if (EXCP_EN) begin
      push_excp(1'b0);
    end
    drain();
  endtask

  task automatic hold_and_release();
    logic [31:0] rv;
    rv = mk(T_RESET, B_RST, 3'b000, 2'b00, 2'b00, 2'b00, 3'b000);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_vec("rst_hold", dut_vec, rv);
    end
    #1 reset = 1'b1;
    #1 check_vec("rst_release", dut_vec, rv);
    push_reset(RC - 1);
    drain();
  endtask

  initial begin
    logic [5:0] op, fn;
    n_vec = 0; n_err = 0;
    reset = 1'b0; Of = 1'b0; OPCode = '0; funct = '0;
    cur_op = '0; cur_fn = '0; cur_of = 1'b0;

    hold_and_release();

    run_instr(6'b000000, 6'b100000, 1'b0);   // ADD
    run_instr(6'b001000, 6'b010101, 1'b0);   // ADDI
    run_instr(6'b000000, 6'b100000, 1'b1);   // ADD overflow
    run_instr(6'b001000, 6'b000000, 1'b1);   // ADDI overflow
    run_instr(6'b010101, 6'b100000, 1'b0);   // invalid opcode
    run_instr(6'b000000, 6'b100010, 1'b0);   // R-type, wrong funct
    run_instr(6'b111111, 6'b000000, 1'b0);   // software reset
    run_instr(6'b000000, 6'b100000, 1'b0);

    // Asynchronous reset while ADD is in writeback
    cur_op = 6'b000000; cur_fn = 6'b100000; cur_of = 1'b0;
    push_fetch(); push_decode(); push_exec(1'b1); push_wb(1'b1);
    drain();
    #2 reset = 1'b0;
    #1 check_vec("async_rst", dut_vec, mk(T_RESET, B_RST, 3'b000, 2'b00, 2'b00, 2'b00, 3'b000));
    hold_and_release();

    for (int k = 0; k < 10; k++) begin
      case ($urandom_range(0, 3))
        0: begin op = 6'b000000; fn = 6'b100000; end
        1: begin op = 6'b001000; fn = 6'($urandom_range(0, 63)); end
        2: begin
          op = 6'($urandom_range(1, 62));
          if (op == 6'b001000) op = 6'b001001;
          fn = 6'($urandom_range(0, 63));
        end
        default: begin
          op = 6'b000000; fn = 6'($urandom_range(0, 31));
        end
      endcase
      run_instr(op, fn, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
